// File: rtl/accumulator_reader_pkg.sv
// Shared definitions for the Accumulator read path: derived widths and the reader FSM encoding.
// Width helpers are kept here so the Accumulator and its reader cannot drift apart.
package accumulator_reader_pkg;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] READ  = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;

    function automatic int psum_width(input int weight_width, input int activation_width,
                                      input int systolic_size);
        return weight_width + activation_width + $clog2(systolic_size);
    endfunction

    // A single-row buffer still needs a 1-bit address port.
    function automatic int acc_addr_width(input int pattern_number, input int systolic_size);
        return (pattern_number * systolic_size > 1) ? $clog2(pattern_number * systolic_size) : 1;
    endfunction

endpackage

// File: rtl/accumulator_reader_if.sv
// Row stream from the accumulator reader to the host/output path (valid/ready with last marker).
interface accumulator_reader_if #(
    parameter int DATA_WIDTH = 152
);
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_last;

    modport master (
        output out_valid,
        output out_data,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        input  out_last,
        output out_ready
    );
endinterface

// File: rtl/accumulator_reader_fifo.sv
// Two-entry output FIFO for the accumulator reader; the head entry drives the stream directly
// from registers. A push into a full FIFO is accepted only together with a pop.
module acc_rd_fifo #(
    parameter int WIDTH = 153
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    output logic             full,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             empty
);

    logic [WIDTH-1:0] mem_q [2];
    logic             wr_ptr_q;
    logic             rd_ptr_q;
    logic [1:0]       count_q;
    logic             do_push;
    logic             do_pop;

    assign full     = (count_q == 2'd2);
    assign empty    = (count_q == 2'd0);
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem_q[rd_ptr_q];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_data;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (do_pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_q + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

endmodule

// File: rtl/accumulator_reader.sv
// Read-side controller for the Accumulator partial-sum buffer: walks an address window on start
// and streams each full row out through a 2-entry FIFO, flagging the final row with out_last.
module accumulator_reader
    import accumulator_reader_pkg::*;
#(
    parameter int SYSTOLIC_SIZE     = 8,
    parameter int WEIGHT_WIDTH      = 8,
    parameter int ACTIVATION_WIDTH  = 8,
    parameter int PARTIAL_SUM_WIDTH = psum_width(WEIGHT_WIDTH, ACTIVATION_WIDTH, SYSTOLIC_SIZE),
    parameter int PATTERN_NUMBER    = 1,
    parameter int ADDR_WIDTH        = acc_addr_width(PATTERN_NUMBER, SYSTOLIC_SIZE)
) (
    input  logic                                       clk,
    input  logic                                       rst_n,
    input  logic                                       start,
    input  logic [ADDR_WIDTH-1:0]                      base_addr,
    input  logic [ADDR_WIDTH:0]                        row_count,
    output logic                                       busy,
    output logic                                       done,
    output logic [ADDR_WIDTH-1:0]                      rd_addr_outside,
    input  logic [PARTIAL_SUM_WIDTH*SYSTOLIC_SIZE-1:0] partial_sum_outputs_flat,
    accumulator_reader_if.master                       out_if
);

    localparam int ROW_WIDTH = PARTIAL_SUM_WIDTH * SYSTOLIC_SIZE;

    logic [1:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [ADDR_WIDTH:0]   remaining_q, remaining_d;
    logic                  done_q, done_d;

    logic                  fifo_push;
    logic                  fifo_pop;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [ROW_WIDTH:0]    fifo_head;
    logic                  last_row;
    logic                  start_ok;

    assign last_row = (remaining_q == (ADDR_WIDTH + 1)'(1));
    // The done cycle already shows IDLE, so a start there must be masked explicitly.
    assign start_ok = start && (state_q == IDLE) && !done_q;
    assign fifo_pop = !fifo_empty && out_if.out_ready;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        remaining_d = remaining_q;
        done_d      = 1'b0;
        fifo_push   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_ok) begin
                    addr_d      = base_addr;
                    remaining_d = row_count;
                    if (row_count == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = READ;
                    end
                end
            end
            READ: begin
                // Push depends only on the registered fill level, never on out_ready.
                if (!fifo_full) begin
                    fifo_push   = 1'b1;
                    addr_d      = addr_q + ADDR_WIDTH'(1);
                    remaining_d = remaining_q - (ADDR_WIDTH + 1)'(1);
                    if (last_row) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (fifo_pop && fifo_head[ROW_WIDTH]) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            remaining_q <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            remaining_q <= remaining_d;
            done_q      <= done_d;
        end
    end

    acc_rd_fifo #(
        .WIDTH(ROW_WIDTH + 1)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (fifo_push),
        .push_data({last_row, partial_sum_outputs_flat}),
        .full     (fifo_full),
        .pop      (fifo_pop),
        .pop_data (fifo_head),
        .empty    (fifo_empty)
    );

    assign busy             = (state_q != IDLE);
    assign done             = done_q;
    assign rd_addr_outside  = addr_q;
    assign out_if.out_valid = !fifo_empty;
    // Idle bus shows zeros rather than the stale head entry.
    assign out_if.out_data  = fifo_empty ? '0 : fifo_head[ROW_WIDTH-1:0];
    assign out_if.out_last  = !fifo_empty && fifo_head[ROW_WIDTH];

endmodule
